// File: rtl/vec_exec_sequencer.sv
// Execute sequencer for the vector coprocessor: accepts one decoded op, steps the
// lane datapath through element groups, runs the reduction tail, then writes back.
module vec_exec_sequencer #(
  parameter int VLEN  = 128,
  parameter int SEW   = 8,
  parameter int LANES = 4
) (
  input  logic                 vsi_clk,
  input  logic                 vsi_rst,
  input  logic                 vsi_op_valid,
  output logic                 vsi_op_ready,
  output logic                 vsi_cop_idle,
  input  logic                 is_vxor,
  input  logic                 is_vmacc,
  input  logic                 is_vredsum,
  input  logic                 is_vslideup,
  input  logic                 is_vrgather,
  input  logic [7:0]           op_vl,
  output logic                 dp_grp_en,
  output logic [((((VLEN/SEW)+LANES-1)/LANES) > 1 ? $clog2(((VLEN/SEW)+LANES-1)/LANES) : 1)-1:0] dp_grp_idx,
  output logic                 dp_phase,
  output logic                 dp_first,
  output logic                 dp_last,
  output logic                 dp_red_en,
  output logic                 wb_en,
  input  logic                 wb_ready,
  output logic                 op_err
);

  localparam int VLMAX   = VLEN / SEW;
  localparam int GRP_MAX = (VLMAX + LANES - 1) / LANES;
  localparam int GW      = (GRP_MAX > 1) ? $clog2(GRP_MAX) : 1;
  localparam int RED_CYC = $clog2(LANES);
  localparam int RW      = (RED_CYC > 0) ? $clog2(RED_CYC + 1) : 1;

  typedef enum logic [2:0] {S_IDLE, S_EXEC, S_RED, S_WB, S_ERR} state_t;

  state_t          state_q, state_d;
  logic [GW-1:0]   grp_q, grp_d;
  logic [GW-1:0]   last_grp_q, last_grp_d;
  logic            phase_q, phase_d;
  logic [RW-1:0]   red_cnt_q, red_cnt_d;
  logic            is_red_q, is_red_d;
  logic            is_gth_q, is_gth_d;
  logic [7:0]      vl_eff;
  logic            last_cyc;
  logic            run;

  // Oversized vl saturates at VLMAX rather than wrapping.
  assign vl_eff   = (32'(op_vl) > VLMAX) ? 8'(VLMAX) : op_vl;
  assign last_cyc = (grp_q == last_grp_q) && (!is_gth_q || phase_q);
  assign run      = !vsi_rst;

  always_comb begin
    state_d    = state_q;
    grp_d      = grp_q;
    last_grp_d = last_grp_q;
    phase_d    = phase_q;
    red_cnt_d  = red_cnt_q;
    is_red_d   = is_red_q;
    is_gth_d   = is_gth_q;
    unique case (state_q)
      S_IDLE: begin
        if (vsi_op_valid) begin
          is_red_d   = is_vredsum;
          is_gth_d   = is_vrgather;
          last_grp_d = GW'((vl_eff - 8'd1) / 8'(LANES));
          grp_d      = '0;
          phase_d    = 1'b0;
          red_cnt_d  = '0;
          if (!$onehot({is_vxor, is_vmacc, is_vredsum, is_vslideup, is_vrgather}))
            state_d = S_ERR;
          else if (vl_eff == 8'd0)
            state_d = S_IDLE;
          else
            state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (is_gth_q && !phase_q) begin
          phase_d = 1'b1;
        end else begin
          phase_d = 1'b0;
          if (!last_cyc) grp_d = grp_q + GW'(1);
        end
        if (last_cyc) begin
          red_cnt_d = '0;
          state_d   = (is_red_q && RED_CYC > 0) ? S_RED : S_WB;
        end
      end
      S_RED: begin
        red_cnt_d = red_cnt_q + RW'(1);
        if (red_cnt_q == RW'(RED_CYC - 1)) state_d = S_WB;
      end
      S_WB:    if (wb_ready) state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge vsi_clk) begin
    if (vsi_rst) begin
      state_q    <= S_IDLE;
      grp_q      <= '0;
      last_grp_q <= '0;
      phase_q    <= 1'b0;
      red_cnt_q  <= '0;
      is_red_q   <= 1'b0;
      is_gth_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      grp_q      <= grp_d;
      last_grp_q <= last_grp_d;
      phase_q    <= phase_d;
      red_cnt_q  <= red_cnt_d;
      is_red_q   <= is_red_d;
      is_gth_q   <= is_gth_d;
    end
  end

  // Every output is forced low while reset is held, regardless of stored state.
  assign vsi_op_ready = run && (state_q == S_IDLE);
  assign vsi_cop_idle = run && (state_q == S_IDLE);
  assign dp_grp_en    = run && (state_q == S_EXEC);
  assign dp_grp_idx   = dp_grp_en ? grp_q : '0;
  assign dp_phase     = dp_grp_en && phase_q;
  assign dp_first     = dp_grp_en && (grp_q == '0) && !phase_q;
  assign dp_last      = dp_grp_en && last_cyc;
  assign dp_red_en    = run && (state_q == S_RED);
  assign wb_en        = run && (state_q == S_WB);
  assign op_err       = run && (state_q == S_ERR);

endmodule

// File: tb/tb_vec_exec_sequencer.sv
// Directed bench for vec_exec_sequencer: table of ops with hand-computed cycle
// counts, plus reset sequences at power-up and mid-operation.
module tb_vec_exec_sequencer;

  localparam int GW = 2;

  logic          vsi_clk = 1'b0;
  logic          vsi_rst;
  logic          vsi_op_valid;
  logic          vsi_op_ready, vsi_cop_idle;
  logic          is_vxor, is_vmacc, is_vredsum, is_vslideup, is_vrgather;
  logic [7:0]    op_vl;
  logic          dp_grp_en;
  logic [GW-1:0] dp_grp_idx;
  logic          dp_phase, dp_first, dp_last, dp_red_en, wb_en, wb_ready, op_err;

  int tests_run = 0;
  int tests_failed = 0;

  vec_exec_sequencer dut (
    .vsi_clk(vsi_clk), .vsi_rst(vsi_rst), .vsi_op_valid(vsi_op_valid),
    .vsi_op_ready(vsi_op_ready), .vsi_cop_idle(vsi_cop_idle),
    .is_vxor(is_vxor), .is_vmacc(is_vmacc), .is_vredsum(is_vredsum),
    .is_vslideup(is_vslideup), .is_vrgather(is_vrgather), .op_vl(op_vl),
    .dp_grp_en(dp_grp_en), .dp_grp_idx(dp_grp_idx), .dp_phase(dp_phase),
    .dp_first(dp_first), .dp_last(dp_last), .dp_red_en(dp_red_en),
    .wb_en(wb_en), .wb_ready(wb_ready), .op_err(op_err)
  );

  always #5 vsi_clk = ~vsi_clk;

  // isv bit order: {vxor, vmacc, vredsum, vslideup, vrgather}
  typedef struct {
    logic [4:0] isv;
    logic [7:0] vl;
    int         stall;
    int         e_exec;
    int         e_red;
    int         e_wb;
    int         e_err;
    int         e_rdy;
  } vec_t;

  localparam int NV = 11;
  vec_t tbl [NV];

  task automatic chk(input string name, input int act, input int exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [GW+8:0] all_outs();
    return {vsi_op_ready, vsi_cop_idle, dp_grp_en, dp_phase, dp_first, dp_last,
            dp_red_en, wb_en, op_err, dp_grp_idx};
  endfunction

  task automatic run_vec(input int id, input vec_t v);
    int n_exec = 0, n_red = 0, n_wb = 0, n_err = 0, rdy = -1;
    int seq_bad = 0, idle_bad = 0;
    bit gth;
    int k;
    gth = (v.isv == 5'b00001);
    @(negedge vsi_clk);
    {is_vxor, is_vmacc, is_vredsum, is_vslideup, is_vrgather} = v.isv;
    op_vl        = v.vl;
    vsi_op_valid = 1'b1;
    wb_ready     = 1'b1;
    @(negedge vsi_clk);
    vsi_op_valid = 1'b0;
    {is_vxor, is_vmacc, is_vredsum, is_vslideup, is_vrgather} = 5'b0;
    op_vl = 8'd0;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      if (vsi_op_ready) begin
        rdy = cyc;
        break;
      end
      if (vsi_cop_idle) idle_bad++;
      if (dp_grp_en) begin
        k = n_exec;
        if (int'(dp_grp_idx) != (gth ? k / 2 : k)) seq_bad++;
        if (dp_phase != (gth ? k[0] : 1'b0)) seq_bad++;
        if (dp_first != (k == 0)) seq_bad++;
        if (dp_last != (k == v.e_exec - 1)) seq_bad++;
        if (dp_red_en || wb_en) seq_bad++;
        n_exec++;
      end
      if (dp_red_en) n_red++;
      if (op_err) n_err++;
      if (wb_en) begin
        n_wb++;
        wb_ready = (n_wb > v.stall);
      end else begin
        wb_ready = 1'b1;
      end
      @(negedge vsi_clk);
    end
    chk($sformatf("v%0d_exec_cycles", id), n_exec, v.e_exec);
    chk($sformatf("v%0d_red_cycles", id), n_red, v.e_red);
    chk($sformatf("v%0d_wb_cycles", id), n_wb, v.e_wb);
    chk($sformatf("v%0d_err_pulses", id), n_err, v.e_err);
    chk($sformatf("v%0d_ready_cycle", id), rdy, v.e_rdy);
    chk($sformatf("v%0d_exec_seq_errs", id), seq_bad, 0);
    chk($sformatf("v%0d_idle_while_busy", id), idle_bad, 0);
  endtask

  initial begin
    int found;
    int wb_seen;
    tbl[0]  = '{5'b10000, 8'd16,  0, 4, 0, 1, 0, 6};   // vxor full length
    tbl[1]  = '{5'b00100, 8'd6,   0, 2, 2, 1, 0, 6};   // vredsum, partial group
    tbl[2]  = '{5'b00001, 8'd9,   0, 6, 0, 1, 0, 8};   // vrgather, 3 groups x 2 phases
    tbl[3]  = '{5'b01000, 8'd200, 5, 4, 0, 6, 0, 11};  // vmacc clamp + wb stall
    tbl[4]  = '{5'b11000, 8'd4,   0, 0, 0, 0, 1, 2};   // two class bits set
    tbl[5]  = '{5'b10000, 8'd0,   0, 0, 0, 0, 0, 1};   // vl=0 completes at once
    tbl[6]  = '{5'b00010, 8'd5,   0, 2, 0, 1, 0, 4};   // vslideup
    tbl[7]  = '{5'b00001, 8'd1,   0, 2, 0, 1, 0, 4};   // vrgather single group
    tbl[8]  = '{5'b00100, 8'd16,  0, 4, 2, 1, 0, 8};   // vredsum full
    tbl[9]  = '{5'b00000, 8'd8,   0, 0, 0, 0, 1, 2};   // no class bit
    tbl[10] = '{5'b10000, 8'd17,  0, 4, 0, 1, 0, 6};   // just over VLMAX

    vsi_rst = 1'b1;
    vsi_op_valid = 1'b0;
    {is_vxor, is_vmacc, is_vredsum, is_vslideup, is_vrgather} = 5'b0;
    op_vl = 8'd0;
    wb_ready = 1'b0;
    repeat (2) @(negedge vsi_clk);
    chk("reset_outputs_zero", int'(all_outs()), 0);
    vsi_rst = 1'b0;
    @(negedge vsi_clk);
    chk("post_reset_ready", int'(vsi_op_ready), 1);
    chk("post_reset_idle", int'(vsi_cop_idle), 1);

    for (int i = 0; i < NV; i++) run_vec(i, tbl[i]);

    // Reset during EXEC group 2 abandons the op without a writeback.
    @(negedge vsi_clk);
    is_vxor = 1'b1;
    op_vl = 8'd16;
    vsi_op_valid = 1'b1;
    wb_ready = 1'b1;
    @(negedge vsi_clk);
    vsi_op_valid = 1'b0;
    is_vxor = 1'b0;
    found = 0;
    for (int c = 0; c < 10; c++) begin
      if (dp_grp_en && dp_grp_idx == 2'd2) begin
        found = 1;
        break;
      end
      @(negedge vsi_clk);
    end
    chk("rst_mid_reached_idx2", found, 1);
    vsi_rst = 1'b1;
    @(negedge vsi_clk);
    chk("rst_mid_outputs_zero", int'(all_outs()), 0);
    vsi_rst = 1'b0;
    @(negedge vsi_clk);
    chk("rst_mid_ready_after", int'(vsi_op_ready), 1);
    wb_seen = 0;
    for (int c = 0; c < 6; c++) begin
      if (wb_en || dp_grp_en) wb_seen++;
      @(negedge vsi_clk);
    end
    chk("rst_mid_no_wb", wb_seen, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
